// File: rtl/aes_pkg.sv
// Shared AES types and constant tables used by the key schedule and
// the cipher's SubBytes stage.
package aes_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [3:0] state_t;

    localparam int unsigned NR_128 = 10;

    typedef enum logic {
        KE_IDLE,
        KE_EMIT
    } ke_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Left byte rotate: {b3,b2,b1,b0} -> {b2,b1,b0,b3}.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rounds outside 1..10 map to zero so the lookup never leaves the table.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] c;
        c = 8'h00;
        if (r >= 4'd1 && r <= 4'd10) begin
            c = RCON[r];
        end
        return c;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: AES S-box applied to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] w_i,
    output logic [31:0] w_o
);

    always_comb begin
        w_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_o[8*i +: 8] = SBOX[w_i[8*i +: 8]];
        end
    end

endmodule

// File: rtl/key_expand_unit.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a
// valid/ready handshake, one new key per accepted handshake.
module key_expand_unit
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  state_t     key_i,
    output state_t     rk_o,
    output logic [3:0] rk_round_o,
    output logic       rk_valid_o,
    input  logic       rk_ready_i,
    output logic       busy_o,
    output logic       done_o
);

    if (NUM_ROUNDS != NR_128) begin : g_bad_rounds
        $error("key_expand_unit: only NUM_ROUNDS = 10 (AES-128) is supported");
    end

    ke_state_e  state_q, state_d;
    state_t     rk_q, rk_d;
    logic [3:0] round_q, round_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;

    logic [3:0] next_round;
    word_t      rot_w;
    word_t      sub_w;
    word_t      t_w;
    state_t     next_rk;

    assign next_round = round_q + 4'd1;
    assign rot_w      = rot_word(rk_q[3]);

    aes_sub_word u_sub_word (
        .w_i (rot_w),
        .w_o (sub_w)
    );

    // Next key depends only on the registered key, never on key_i.
    always_comb begin
        t_w        = sub_w ^ {rcon_of(next_round), 24'h0};
        next_rk    = '0;
        next_rk[0] = rk_q[0] ^ t_w;
        next_rk[1] = rk_q[1] ^ next_rk[0];
        next_rk[2] = rk_q[2] ^ next_rk[1];
        next_rk[3] = rk_q[3] ^ next_rk[2];
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            KE_IDLE: begin
                if (start_i) begin
                    rk_d    = key_i;
                    round_d = '0;
                    valid_d = 1'b1;
                    state_d = KE_EMIT;
                end
            end
            KE_EMIT: begin
                if (valid_q && rk_ready_i) begin
                    if (round_q == 4'(NUM_ROUNDS)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = KE_IDLE;
                    end else begin
                        rk_d    = next_rk;
                        round_d = next_round;
                    end
                end
            end
            default: begin
                state_d = KE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KE_IDLE;
            rk_q    <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign rk_o       = rk_q;
    assign rk_round_o = round_q;
    assign rk_valid_o = valid_q;
    assign busy_o     = (state_q != KE_IDLE);
    assign done_o     = done_q;

endmodule

// File: tb/tb_key_expand_unit.sv
// Scoreboard bench for key_expand_unit; reference keys come from an
// independent GF(2^8) S-box model plus FIPS-197 known answers.
module tb_key_expand_unit;
    import aes_pkg::*;

    localparam int unsigned M_READY  = 0;
    localparam int unsigned M_RAND   = 1;
    localparam int unsigned M_INJECT = 2;
    localparam int unsigned M_RESET  = 3;

    // Word 0 sits in the low 32 bits of the packed state.
    localparam state_t A1_KEY = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    localparam state_t A1_R1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
    localparam state_t A1_R2  = {32'h7359f67f, 32'h5935807a, 32'h7a96b943, 32'hf2c295f2};
    localparam state_t A1_R10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
    localparam state_t Z_KEY  = '0;
    localparam state_t Z_R1   = {32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363};
    localparam state_t Z_R2   = {32'hf9fbfbaa, 32'h9b9898c9, 32'hf9fbfbaa, 32'h9b9898c9};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    state_t     key_i;
    state_t     rk_o;
    logic [3:0] rk_round_o;
    logic       rk_valid_o;
    logic       rk_ready_i;
    logic       busy_o;
    logic       done_o;

    always #5 clk = ~clk;

    key_expand_unit #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .key_i      (key_i),
        .rk_o       (rk_o),
        .rk_round_o (rk_round_o),
        .rk_valid_o (rk_valid_o),
        .rk_ready_i (rk_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    typedef struct packed {
        logic [3:0] round;
        state_t     rk;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  ref_sbox [256];

    bit          hold_pend;
    state_t      hold_rk;
    logic [3:0]  hold_round;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (a != 8'h00 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic state_t ref_next(input state_t k, input int unsigned r);
        logic [7:0] c;
        word_t      w;
        word_t      t;
        state_t     n;
        c = 8'h01;
        for (int unsigned i = 1; i < r; i++) c = gmul(c, 8'h02);
        w = {k[3][23:0], k[3][31:24]};
        for (int i = 0; i < 4; i++) t[8*i +: 8] = ref_sbox[w[8*i +: 8]];
        t    = t ^ {c, 24'h0};
        n[0] = k[0] ^ t;
        n[1] = k[1] ^ n[0];
        n[2] = k[2] ^ n[1];
        n[3] = k[3] ^ n[2];
        return n;
    endfunction

    task automatic push_schedule(input state_t key, output state_t last);
        state_t k;
        k = key;
        for (int unsigned r = 0; r <= 10; r++) begin
            exp_q.push_back('{round: 4'(r), rk: k});
            last = k;
            if (r < 10) k = ref_next(k, r + 1);
        end
    endtask

    task automatic fips_check(input state_t key, input logic [3:0] r, input state_t got);
        if (key == A1_KEY) begin
            if (r == 4'd1)       chk("a1_round1", got, A1_R1);
            else if (r == 4'd2)  chk("a1_round2", got, A1_R2);
            else if (r == 4'd10) chk("a1_round10", got, A1_R10);
        end else if (key == Z_KEY) begin
            if (r == 4'd1)       chk("zero_round1", got, Z_R1);
            else if (r == 4'd2)  chk("zero_round2", got, Z_R2);
        end
    endtask

    // Handshake and stall monitor, sampled mid-cycle ahead of the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("stall_rk", rk_o, hold_rk);
                chk("stall_round", rk_round_o, hold_round);
                chk("stall_valid", rk_valid_o, 1);
            end
            hold_pend = 1'b0;
            if (rk_valid_o && rk_ready_i) begin
                chk("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_round", rk_round_o, e.round);
                    chk("sb_key", rk_o, e.rk);
                end
            end else if (rk_valid_o) begin
                hold_pend  = 1'b1;
                hold_rk    = rk_o;
                hold_round = rk_round_o;
            end
        end
    end

    task automatic run_key(input state_t key, input int unsigned mode, input bit chain);
        int unsigned cyc;
        int unsigned nvalid;
        int unsigned low_left;
        int          last_fips;
        bit          inj;
        bit          inj_seen;
        state_t      final_rk;
        push_schedule(key, final_rk);
        start_i = 1'b1;
        key_i   = key;
        @(posedge clk); #1;
        start_i = 1'b0;
        key_i   = ~key;
        chk("first_valid", rk_valid_o, 1);
        chk("first_busy", busy_o, 1);
        chk("first_round", rk_round_o, 0);
        chk("done_low_after_start", done_o, 0);
        nvalid = 0; cyc = 0; low_left = 0; last_fips = -1; inj = 1'b0; inj_seen = 1'b0;
        while (!done_o && cyc < 400) begin
            if (rk_valid_o) nvalid++;
            if (rk_valid_o && int'(rk_round_o) != last_fips) begin
                last_fips = int'(rk_round_o);
                fips_check(key, rk_round_o, rk_o);
            end
            start_i = 1'b0;
            if (mode == M_RAND) begin
                if (cyc == 3) low_left = 5;
                if (low_left > 0) begin
                    rk_ready_i = 1'b0;
                    low_left--;
                end else begin
                    rk_ready_i = ($urandom_range(0, 2) != 0);
                end
            end else begin
                rk_ready_i = 1'b1;
            end
            if (mode == M_INJECT && !inj && rk_valid_o && rk_round_o == 4'd4) begin
                start_i = 1'b1;
                key_i   = Z_KEY;
                inj     = 1'b1;
            end
            if (mode == M_RESET && rk_valid_o && rk_round_o == 4'd6) begin
                rst_n = 1'b0;
                #1;
                chk("rst_rk", rk_o, '0);
                chk("rst_round", rk_round_o, 0);
                chk("rst_valid", rk_valid_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_done", done_o, 0);
                exp_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            cyc++;
            if (inj && !inj_seen) begin
                inj_seen = 1'b1;
                chk("busy_ignores_start", busy_o, 1);
                chk("round_ignores_start", rk_round_o, 5);
            end
        end
        chk("done_seen", done_o, 1);
        if (mode != M_RAND) chk("valid_cycles", nvalid, 11);
        chk("valid_after_done", rk_valid_o, 0);
        chk("busy_after_done", busy_o, 0);
        chk("rk_kept", rk_o, final_rk);
        chk("round_kept", rk_round_o, 10);
        chk("sb_drained", exp_q.size(), 0);
        if (!chain) begin
            @(posedge clk); #1;
            chk("done_pulse_width", done_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_calc(8'(i));
        rst_n      = 1'b0;
        start_i    = 1'b0;
        rk_ready_i = 1'b0;
        key_i      = '0;
        hold_pend  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rk", rk_o, '0);
        chk("reset_round", rk_round_o, 0);
        chk("reset_valid", rk_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        rst_n      = 1'b1;
        rk_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("idle_valid_hold", rk_valid_o, 0);
        chk("idle_busy_hold", busy_o, 0);

        run_key(A1_KEY, M_READY, 1'b0);
        run_key(Z_KEY, M_READY, 1'b0);
        run_key(A1_KEY, M_RAND, 1'b0);
        run_key(A1_KEY, M_INJECT, 1'b0);
        run_key(A1_KEY, M_RESET, 1'b0);
        run_key(A1_KEY, M_READY, 1'b1);
        run_key(Z_KEY, M_READY, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
